// File: rtl/svc_rv_dmem_cache_pkg.sv
// Shared types and helpers for the svc_rv direct-mapped write-through data cache.
package svc_rv_dmem_cache_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_REQ  = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        RD_REQ  = ST_RD_REQ,
        RD_WAIT = ST_RD_WAIT
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] data,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = data;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end else begin
                merged[8*b +: 8] = data[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/svc_rv_dmem_cache_chk.sv
// Protocol checks on the core-side request interface.
module svc_rv_dmem_cache_chk (
    input logic clk,
    input logic rst_n,
    input logic ren,
    input logic we
);

    // A core never issues a read and a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(ren && we));
        end
    end

endmodule

// File: rtl/svc_rv_dmem_wbuf.sv
// One-entry write buffer feeding the backing-memory write channel.
module svc_rv_dmem_wbuf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [3:0]  strb,
    input  logic        wr_ready,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_strb,
    output logic        full
);

    logic        full_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic [3:0]  strb_r;

    // Entry load has priority so a new write can replace an entry draining this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            addr_r <= 32'd0;
            data_r <= 32'd0;
            strb_r <= 4'd0;
        end else if (load) begin
            full_r <= 1'b1;
            addr_r <= addr;
            data_r <= data;
            strb_r <= strb;
        end else if (wr_ready) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign wr_valid = full_r;
    assign full     = full_r;
    assign wr_addr  = addr_r;
    assign wr_data  = data_r;
    assign wr_strb  = strb_r;

endmodule

// File: rtl/svc_rv_dmem_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with BRAM-style read timing.
module svc_rv_dmem_cache
    import svc_rv_dmem_cache_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_ren,
    input  logic [31:0] dmem_raddr,
    output logic [31:0] dmem_rdata,
    input  logic        dmem_we,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_stall,
    output logic        m_rd_valid,
    output logic [31:0] m_rd_addr,
    input  logic        m_rd_ready,
    input  logic        m_rdata_valid,
    input  logic [31:0] m_rdata,
    output logic        m_wr_valid,
    output logic [31:0] m_wr_addr,
    output logic [31:0] m_wr_data,
    output logic [3:0]  m_wr_strb,
    input  logic        m_wr_ready
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]      data_r [DEPTH];
    logic [TAG_W-1:0] tag_r  [DEPTH];
    logic [DEPTH-1:0] valid_r;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] rd_addr_r;
    logic        rd_valid_r;
    logic [31:0] rdata_r;

    logic [IDX_W-1:0] ridx_s, widx_s, fidx_s;
    logic [TAG_W-1:0] rtag_s, wtag_s, ftag_s;
    logic             hit_s, whit_s, stall_s, rd_acc_s, wr_acc_s, fill_s, wb_full_s;

    assign ridx_s = dmem_raddr[2 +: IDX_W];
    assign rtag_s = dmem_raddr[31 : 2+IDX_W];
    assign widx_s = dmem_waddr[2 +: IDX_W];
    assign wtag_s = dmem_waddr[31 : 2+IDX_W];
    assign fidx_s = rd_addr_r[2 +: IDX_W];
    assign ftag_s = rd_addr_r[31 : 2+IDX_W];

    assign hit_s    = dmem_ren && valid_r[ridx_s] && (tag_r[ridx_s] == rtag_s);
    assign whit_s   = valid_r[widx_s] && (tag_r[widx_s] == wtag_s);
    assign stall_s  = (dmem_ren && !hit_s) || (dmem_we && wb_full_s && !m_wr_ready);
    assign rd_acc_s = dmem_ren && !stall_s;
    assign wr_acc_s = dmem_we && !stall_s;
    assign fill_s   = (state_r == RD_WAIT) && m_rdata_valid;

    // Read-miss sequencing; a pending write must drain before the fill is requested.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (dmem_ren && !hit_s && !wb_full_s) begin
                    state_nx_s = RD_REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RD_REQ: begin
                if (m_rd_ready) begin
                    state_nx_s = RD_WAIT;
                end else begin
                    state_nx_s = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (m_rdata_valid) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RD_WAIT;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM state, latched miss address and registered read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rd_addr_r  <= 32'd0;
            rd_valid_r <= 1'b0;
            rdata_r    <= 32'd0;
        end else begin
            state_r    <= state_nx_s;
            rd_valid_r <= (state_nx_s == RD_REQ);
            if (state_r == IDLE && state_nx_s == RD_REQ) begin
                rd_addr_r <= dmem_raddr;
            end
            if (rd_acc_s) begin
                rdata_r <= data_r[ridx_s];
            end
        end
    end

    // Line arrays: write hits merge bytes, fills replace the whole line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= 32'd0;
                tag_r[i]  <= '0;
            end
        end else begin
            if (wr_acc_s && whit_s) begin
                data_r[widx_s] <= merge_bytes(data_r[widx_s], dmem_wdata, dmem_wstrb);
            end
            if (fill_s) begin
                data_r[fidx_s]  <= m_rdata;
                tag_r[fidx_s]   <= ftag_s;
                valid_r[fidx_s] <= 1'b1;
            end
        end
    end

    svc_rv_dmem_wbuf u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wr_acc_s),
        .addr     (dmem_waddr),
        .data     (dmem_wdata),
        .strb     (dmem_wstrb),
        .wr_ready (m_wr_ready),
        .wr_valid (m_wr_valid),
        .wr_addr  (m_wr_addr),
        .wr_data  (m_wr_data),
        .wr_strb  (m_wr_strb),
        .full     (wb_full_s)
    );

    svc_rv_dmem_cache_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .ren   (dmem_ren),
        .we    (dmem_we)
    );

    assign dmem_stall = stall_s;
    assign dmem_rdata = rdata_r;
    assign m_rd_valid = rd_valid_r;
    assign m_rd_addr  = rd_addr_r;

endmodule

// File: tb/tb_svc_rv_dmem_cache.sv
// Directed bench for svc_rv_dmem_cache: vector table plus hand sequences for back-pressure and reset.
module tb_svc_rv_dmem_cache;

    logic        clk;
    logic        rst_n;
    logic        dmem_ren;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_stall;
    logic        m_rd_valid;
    logic [31:0] m_rd_addr;
    logic        m_rd_ready;
    logic        m_rdata_valid;
    logic [31:0] m_rdata;
    logic        m_wr_valid;
    logic [31:0] m_wr_addr;
    logic [31:0] m_wr_data;
    logic [3:0]  m_wr_strb;
    logic        m_wr_ready;

    int checks = 0;
    int errors = 0;

    svc_rv_dmem_cache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dmem_ren      (dmem_ren),
        .dmem_raddr    (dmem_raddr),
        .dmem_rdata    (dmem_rdata),
        .dmem_we       (dmem_we),
        .dmem_waddr    (dmem_waddr),
        .dmem_wdata    (dmem_wdata),
        .dmem_wstrb    (dmem_wstrb),
        .dmem_stall    (dmem_stall),
        .m_rd_valid    (m_rd_valid),
        .m_rd_addr     (m_rd_addr),
        .m_rd_ready    (m_rd_ready),
        .m_rdata_valid (m_rdata_valid),
        .m_rdata       (m_rdata),
        .m_wr_valid    (m_wr_valid),
        .m_wr_addr     (m_wr_addr),
        .m_wr_data     (m_wr_data),
        .m_wr_strb     (m_wr_strb),
        .m_wr_ready    (m_wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic [31:0] raddr;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rd_ready;
        logic        rdv;
        logic [31:0] rdat;
        logic        wr_ready;
        logic        e_stall;
        logic        e_rdv;
        logic [31:0] e_rdaddr;
        logic        e_wrv;
        logic [31:0] e_wraddr;
        logic [31:0] e_wrdata;
        logic [3:0]  e_wrstrb;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic drive(input logic ren, input logic [31:0] raddr, input logic we,
                         input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic rd_ready, input logic rdv, input logic [31:0] rdat,
                         input logic wr_ready);
        @(posedge clk);
        #1;
        dmem_ren      = ren;
        dmem_raddr    = raddr;
        dmem_we       = we;
        dmem_waddr    = waddr;
        dmem_wdata    = wdata;
        dmem_wstrb    = wstrb;
        m_rd_ready    = rd_ready;
        m_rdata_valid = rdv;
        m_rdata       = rdat;
        m_wr_ready    = wr_ready;
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy, input logic rdv, input logic [31:0] d,
                      input logic wrdy);
        drive(1'b1, a, 1'b0, 32'd0, 32'd0, 4'd0, rdy, rdv, d, wrdy);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic wrdy);
        drive(1'b0, 32'd0, 1'b1, a, d, s, 1'b1, 1'b0, 32'd0, wrdy);
    endtask

    task automatic idle(input logic wrdy);
        drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, wrdy);
    endtask

    initial begin
        // cold miss and fill of 0x40, hit, partial write, alias refill via 0x80, re-miss of 0x40
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1,
                     1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[3]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0};
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 32'h40, 32'h11223344, 4'b0011, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b1, 32'h40, 32'h11223344, 4'b0011, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[9]  = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[10] = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[11] = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[12] = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[13] = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1,
                     1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[14] = '{1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD3344};
        vecs[15] = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D};
        vecs[16] = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D};
        vecs[17] = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h12345678, 1'b1,
                     1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D};
        vecs[18] = '{1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D};
        vecs[19] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678};

        rst_n = 1'b0;
        dmem_ren = 1'b0; dmem_raddr = 32'd0; dmem_we = 1'b0; dmem_waddr = 32'd0;
        dmem_wdata = 32'd0; dmem_wstrb = 4'd0; m_rd_ready = 1'b1; m_rdata_valid = 1'b0;
        m_rdata = 32'd0; m_wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        chk("rst_rdata", dmem_rdata, 32'd0);
        chk("rst_stall", {31'd0, dmem_stall}, 32'd0);
        chk("rst_rd_valid", {31'd0, m_rd_valid}, 32'd0);
        chk("rst_rd_addr", m_rd_addr, 32'd0);
        chk("rst_wr_valid", {31'd0, m_wr_valid}, 32'd0);
        chk("rst_wr_addr", m_wr_addr, 32'd0);
        chk("rst_wr_data", m_wr_data, 32'd0);
        chk("rst_wr_strb", {28'd0, m_wr_strb}, 32'd0);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].ren, vecs[i].raddr, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].wstrb, vecs[i].rd_ready, vecs[i].rdv, vecs[i].rdat, vecs[i].wr_ready);
            chk($sformatf("v%0d_stall", i), {31'd0, dmem_stall}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_rd_valid", i), {31'd0, m_rd_valid}, {31'd0, vecs[i].e_rdv});
            chk($sformatf("v%0d_rd_addr", i), m_rd_addr, vecs[i].e_rdaddr);
            chk($sformatf("v%0d_wr_valid", i), {31'd0, m_wr_valid}, {31'd0, vecs[i].e_wrv});
            chk($sformatf("v%0d_rdata", i), dmem_rdata, vecs[i].e_rdata);
            if (vecs[i].e_wrv) begin
                chk($sformatf("v%0d_wr_addr", i), m_wr_addr, vecs[i].e_wraddr);
                chk($sformatf("v%0d_wr_data", i), m_wr_data, vecs[i].e_wrdata);
                chk($sformatf("v%0d_wr_strb", i), {28'd0, m_wr_strb}, {28'd0, vecs[i].e_wrstrb});
            end
        end

        // Write back-pressure: second write stalls until the first drains, then both appear in order
        wr(32'h200, 32'hAAAA0001, 4'hF, 1'b0);
        chk("bp_w1_stall", {31'd0, dmem_stall}, 32'd0);
        wr(32'h204, 32'hBBBB0002, 4'hF, 1'b0);
        chk("bp_w2_stall", {31'd0, dmem_stall}, 32'd1);
        chk("bp_w1_out_addr", m_wr_addr, 32'h200);
        chk("bp_w1_out_data", m_wr_data, 32'hAAAA0001);
        wr(32'h204, 32'hBBBB0002, 4'hF, 1'b0);
        chk("bp_w2_stall_hold", {31'd0, dmem_stall}, 32'd1);
        chk("bp_w1_hold_addr", m_wr_addr, 32'h200);
        chk("bp_w1_hold_valid", {31'd0, m_wr_valid}, 32'd1);
        wr(32'h204, 32'hBBBB0002, 4'hF, 1'b1);
        chk("bp_drain_stall", {31'd0, dmem_stall}, 32'd0);
        chk("bp_drain_addr", m_wr_addr, 32'h200);
        idle(1'b1);
        chk("bp_w2_valid", {31'd0, m_wr_valid}, 32'd1);
        chk("bp_w2_addr", m_wr_addr, 32'h204);
        chk("bp_w2_data", m_wr_data, 32'hBBBB0002);
        idle(1'b1);
        chk("bp_empty", {31'd0, m_wr_valid}, 32'd0);

        // Read miss behind a pending write: no fill request until the write drains
        wr(32'h100, 32'hC0C0C0C0, 4'hF, 1'b0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("ord_stall0", {31'd0, dmem_stall}, 32'd1);
        chk("ord_rdv0", {31'd0, m_rd_valid}, 32'd0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("ord_rdv1", {31'd0, m_rd_valid}, 32'd0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("ord_stall2", {31'd0, dmem_stall}, 32'd1);
        chk("ord_rdv2", {31'd0, m_rd_valid}, 32'd0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("ord_wr_gone", {31'd0, m_wr_valid}, 32'd0);
        chk("ord_rdv3", {31'd0, m_rd_valid}, 32'd0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("ord_rdv4", {31'd0, m_rd_valid}, 32'd1);
        chk("ord_rdaddr", m_rd_addr, 32'h100);
        rd(32'h100, 1'b1, 1'b1, 32'h55AA55AA, 1'b1);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("ord_hit_stall", {31'd0, dmem_stall}, 32'd0);
        idle(1'b1);
        chk("ord_rdata", dmem_rdata, 32'h55AA55AA);

        // Reset while a fill is outstanding
        rd(32'h144, 1'b1, 1'b0, 32'd0, 1'b1);
        rd(32'h144, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("mr_rdv", {31'd0, m_rd_valid}, 32'd1);
        chk("mr_rdaddr", m_rd_addr, 32'h144);
        rd(32'h144, 1'b1, 1'b0, 32'd0, 1'b1);
        rst_n = 1'b0;
        idle(1'b1);
        rst_n = 1'b1;
        #1;
        chk("mr_rdata", dmem_rdata, 32'd0);
        chk("mr_rd_valid", {31'd0, m_rd_valid}, 32'd0);
        chk("mr_rd_addr", m_rd_addr, 32'd0);
        chk("mr_wr_valid", {31'd0, m_wr_valid}, 32'd0);
        chk("mr_wr_addr", m_wr_addr, 32'd0);
        chk("mr_wr_data", m_wr_data, 32'd0);
        chk("mr_wr_strb", {28'd0, m_wr_strb}, 32'd0);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("mr_remiss", {31'd0, dmem_stall}, 32'd1);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("mr_refill_req", {31'd0, m_rd_valid}, 32'd1);
        rd(32'h100, 1'b1, 1'b1, 32'h00000077, 1'b1);
        rd(32'h100, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("mr_refill_hit", {31'd0, dmem_stall}, 32'd0);
        idle(1'b1);
        chk("mr_refill_rdata", dmem_rdata, 32'h00000077);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svc_rv_dmem_cache.md
# svc_rv_dmem_cache

Direct-mapped, write-through, no-write-allocate data cache between the svc_rv core's dmem port and a slower backing memory with valid/ready handshakes. Core side keeps BRAM timing (MEM_TYPE=1): read data one cycle after an accepted read. `dmem_stall` is generated on misses and write-buffer back-pressure, which exercises the core's stall path with real traffic.

## Interface
- `DEPTH`, 16: lines, one 32-bit word each; power of two, ≥2.
- `IDX_W`, $clog2(DEPTH): index width (derived).
- `TAG_W`, 30-IDX_W: tag width (derived).
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `dmem_ren`, `dmem_raddr[31:0]`  in  core read request; word-aligned.
- `dmem_rdata`  out  32  read data, registered.
- `dmem_we`, `dmem_waddr[31:0]`, `dmem_wdata[31:0]`, `dmem_wstrb[3:0]`  in  core write request.
- `dmem_stall`  out  1  combinational. Core holds its request while high.
- `m_rd_valid`, `m_rd_addr[31:0]`  out  backing read request; `m_rd_ready`  in.
- `m_rdata_valid`, `m_rdata[31:0]`  in  backing read response; always accepted.
- `m_wr_valid`, `m_wr_addr[31:0]`, `m_wr_data[31:0]`, `m_wr_strb[3:0]`  out; `m_wr_ready`  in.

## Operation
- Address split: index = addr[2+:IDX_W], tag = addr[31:2+IDX_W]. Bits [1:0] are ignored.
- Tag, valid and data arrays are held in flops, so lookup is combinational.
- hit = ren && valid[idx] && tag[idx]==raddr tag.
- Read FSM states:
  - IDLE: on a read miss with write buffer empty, latch the address and go to RD_REQ. On a read miss with the write buffer full, remain in IDLE (ordering).
  - RD_REQ: `m_rd_valid`=1. On `m_rd_ready`, go to RD_WAIT.
  - RD_WAIT: on `m_rdata_valid`, write data, tag and valid=1 into the line, then go to IDLE.
- `dmem_stall` = (ren && !hit) || (we && wb_full && !m_wr_ready).
- Accepted read (ren && !stall, which implies hit): `dmem_rdata` <= line data.
- Write buffer: one entry (wb_full, addr, data, strb). `m_wr_*` are driven from the entry and `m_wr_valid`=wb_full. The entry clears on `m_wr_ready`.
- Accepted write (we && !stall): load the write buffer. This is allowed in the same cycle the old entry drains.
  - Write hit: merge wdata bytes selected by wstrb into the line; valid and tag unchanged.
  - Write miss: line untouched.
- ren and we asserted together is illegal; it is flagged by an immediate assertion.
- Lines are never evicted except by a fill that overwrites them.

## Timing
- Reset values:
  - `dmem_rdata`=0.
  - All valid bits 0.
  - FSM in IDLE.
  - wb_full=0.
  - `m_rd_valid`=0, `m_wr_valid`=0.
  - `m_rd_addr`, `m_wr_*` = 0.
- Read hit: request in cycle N, data in N+1, held until the next accepted read. No stall.
- Read miss with immediate handshakes, request in cycle N:
  - N: stall.
  - N+1: RD_REQ, `m_rd_valid`.
  - Response arrives in RD_WAIT at N+2 or later, cycle R.
  - R+1: lookup hits and stall drops.
  - R+2: `dmem_rdata` valid.
- `m_rd_valid`, `m_rd_addr`, and `m_wr_*` while `m_wr_valid`=1 stay stable until their ready.
- Write: zero stall when the buffer is empty or draining this cycle. Write data reaches the `m_wr_*` outputs one cycle later.
- Reset mid-fill: FSM returns to IDLE and the outstanding request is dropped. The backing memory shares `rst_n`, so no stale response arrives after reset.
- Index wrap: addresses that differ only in tag alias the same line. A fill replaces the old line.

## Structure
- `svc_rv_dmem_cache_pkg` holds:
  - the `state_t` enum (IDLE, RD_REQ, RD_WAIT);
  - the byte-merge function (data, wdata, wstrb → merged).
- Sub-module `svc_rv_dmem_wbuf` is the one-entry write buffer with its valid/ready output and full flag.
- Arrays and FSM stay in the top module.

## Test plan
- Cold read of 0x40 → stall. `m_rd_addr`=0x40. Response 0xDEADBEEF → stall drops, then `dmem_rdata`=0xDEADBEEF. A second read of 0x40 gives data the next cycle with no stall.
- Read 0x40 after fill, write 0x40 with wdata 0x11223344 and wstrb 4'b0011, read 0x40 → 0xDEAD3344. `m_wr_strb`=4'b0011.
- Fill 0x40, then read 0x80 (same index with DEPTH=16) → miss and refill. A later read of 0x40 misses again.
- Hold `m_wr_ready`=0: first write accepted, second write stalls. Raise ready → second write accepted in the drain cycle and both writes appear in order.
- Write to 0x100 with `m_wr_ready`=0, then read 0x100 → stall persists until the write drains. Only then does `m_rd_valid` rise.
- Assert `rst_n`=0 during RD_WAIT → next cycle all outputs at reset values. A read of the previously filled address misses.
